// File: rtl/mem_loader_if.sv
// Signal bundle around mem_loader: load request, input word stream,
// memory port and CPU-release status.
interface mem_loader_if;
  logic        start;
  logic [15:0] load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic [15:0] addrm;
  logic [15:0] wmdata;
  logic        memwr_en;
  logic [15:0] rmdata;
  logic        owns_bus;
  logic        cpu_reset_n;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  modport master (
    input  start, load_len, in_valid, in_data, rmdata,
    output in_ready, addrm, wmdata, memwr_en, owns_bus, cpu_reset_n,
           done, error, words_loaded
  );

  modport slave (
    output start, load_len, in_valid, in_data, rmdata,
    input  in_ready, addrm, wmdata, memwr_en, owns_bus, cpu_reset_n,
           done, error, words_loaded
  );
endinterface

// File: rtl/mem_loader.sv
// Boot loader: streams words into memory from BASE_ADDR, reads them back,
// and releases the CPU only when the read checksum equals the write checksum.
module mem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'd0
) (
  input  logic         clock,
  input  logic         reset,
  mem_loader_if.master bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAIN, S_VERIFY, S_DONE, S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] words_loaded_q, words_loaded_d;
  logic [15:0] wsum_q, wsum_d;
  logic [15:0] rsum_q, rsum_d;
  logic [15:0] rd_cnt_q, rd_cnt_d;
  logic [15:0] addrm_q, addrm_d;
  logic [15:0] wmdata_q, wmdata_d;
  logic        memwr_en_q, memwr_en_d;
  logic [15:0] rsum_final;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      words_loaded_q <= '0;
      wsum_q         <= '0;
      rsum_q         <= '0;
      rd_cnt_q       <= '0;
      addrm_q        <= '0;
      wmdata_q       <= '0;
      memwr_en_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      words_loaded_q <= words_loaded_d;
      wsum_q         <= wsum_d;
      rsum_q         <= rsum_d;
      rd_cnt_q       <= rd_cnt_d;
      addrm_q        <= addrm_d;
      wmdata_q       <= wmdata_d;
      memwr_en_q     <= memwr_en_d;
    end
  end

  // Read data lags its address by one cycle, so the sum including the
  // word arriving now is what decides pass/fail in the last VERIFY cycle.
  assign rsum_final = rsum_q + bus.rmdata;

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    words_loaded_d = words_loaded_q;
    wsum_d         = wsum_q;
    rsum_d         = rsum_q;
    rd_cnt_d       = rd_cnt_q;
    addrm_d        = addrm_q;
    wmdata_d       = wmdata_q;
    memwr_en_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d          = bus.load_len;
          words_loaded_d = '0;
          wsum_d         = '0;
          rsum_d         = '0;
          state_d        = (bus.load_len == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (bus.in_valid) begin
          memwr_en_d     = 1'b1;
          addrm_d        = BASE_ADDR + words_loaded_q;
          wmdata_d       = bus.in_data;
          words_loaded_d = words_loaded_q + 16'd1;
          wsum_d         = wsum_q + bus.in_data;
          if (words_loaded_d == len_q) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        addrm_d  = BASE_ADDR;
        rd_cnt_d = '0;
        state_d  = S_VERIFY;
      end
      S_VERIFY: begin
        rd_cnt_d = rd_cnt_q + 16'd1;
        if (rd_cnt_q + 16'd1 < len_q) begin
          addrm_d = BASE_ADDR + rd_cnt_q + 16'd1;
        end
        if (rd_cnt_q != 16'd0) begin
          rsum_d = rsum_final;
        end
        if (rd_cnt_q == len_q) begin
          state_d = (rsum_final == wsum_q) ? S_DONE : S_ERROR;
        end
      end
      default: begin
      end
    endcase
  end

  assign bus.in_ready     = (state_q == S_LOAD);
  assign bus.owns_bus     = (state_q == S_LOAD) || (state_q == S_DRAIN) ||
                            (state_q == S_VERIFY);
  assign bus.cpu_reset_n  = (state_q == S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.error        = (state_q == S_ERROR);
  assign bus.addrm        = addrm_q;
  assign bus.wmdata       = wmdata_q;
  assign bus.memwr_en     = memwr_en_q;
  assign bus.words_loaded = words_loaded_q;
endmodule

// File: tb/tb_mem_loader.sv
// Directed bench for mem_loader: two instances (base 0000 and FFFE), memory
// models, an expected-write scoreboard and per-load status checks.
module tb_mem_loader;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset = 1'b1;
  logic        start_s = 1'b0, valid_s = 1'b0, sel = 1'b0;
  logic        corrupt = 1'b0, clr = 1'b0;
  logic [15:0] len_s = '0, data_s = '0;
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] q0[$], q1[$];
  logic [15:0] mem0 [0:65535];
  logic [15:0] mem1 [0:65535];
  logic [15:0] wa [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] wb [5] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};

  mem_loader_if b0();
  mem_loader_if b1();

  mem_loader #(.BASE_ADDR(16'h0000)) u0 (.clock(clock), .reset(reset), .bus(b0));
  mem_loader #(.BASE_ADDR(16'hFFFE)) u1 (.clock(clock), .reset(reset), .bus(b1));

  assign b0.start    = start_s & ~sel;
  assign b1.start    = start_s & sel;
  assign b0.load_len = len_s;
  assign b1.load_len = len_s;
  assign b0.in_valid = valid_s & ~sel;
  assign b1.in_valid = valid_s & sel;
  assign b0.in_data  = data_s;
  assign b1.in_data  = data_s;

  // Synchronous memories with one-cycle read latency; dut0 can corrupt address 2.
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (clr) for (int i = 0; i < 4; i++) mem0[i] <= 16'h0000;
    if (b0.memwr_en)
      mem0[b0.addrm] <= (corrupt && b0.addrm == 16'd2) ? (b0.wmdata ^ 16'h0100) : b0.wmdata;
    b0.rmdata <= mem0[b0.addrm];
    if (b1.memwr_en) mem1[b1.addrm] <= b1.wmdata;
    b1.rmdata <= mem1[b1.addrm];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic sb(input int d, input logic wr, input logic [15:0] a, input logic [15:0] w);
    logic [31:0] e;
    if (wr) begin
      checks++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        errors++;
        $display("FAIL write_unexpected dut%0d: got addr=%h data=%h, required no write", d, a, w);
      end else begin
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        if ({a, w} !== e) begin
          errors++;
          $display("FAIL write dut%0d: got addr=%h data=%h, required addr=%h data=%h",
                   d, a, w, e[31:16], e[15:0]);
        end
      end
    end
  endtask

  task automatic inv(input int d, input logic dn, input logic er, input logic cr);
    checks++;
    if ((dn & er) || (cr !== dn)) begin
      errors++;
      $display("FAIL status_consistency dut%0d: got done=%b error=%b cpu_reset_n=%b, required done&error=0 and cpu_reset_n=done",
               d, dn, er, cr);
    end
  endtask

  always @(negedge clock) begin
    sb(0, b0.memwr_en, b0.addrm, b0.wmdata);
    sb(1, b1.memwr_en, b1.addrm, b1.wmdata);
    inv(0, b0.done, b0.error, b0.cpu_reset_n);
    inv(1, b1.done, b1.error, b1.cpu_reset_n);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; start_s = 1'b0; valid_s = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic start_load(input logic d, input logic [15:0] len);
    sel = d; len_s = len; start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  // Drive one accepted word and record the write the loader must make for it.
  task automatic beat(input int d, input logic [15:0] base, input int idx, input logic [15:0] w);
    logic [15:0] ea;
    ea = base + 16'(idx);
    valid_s = 1'b1; data_s = w;
    if (d == 0) q0.push_back({ea, w});
    else        q1.push_back({ea, w});
    tick();
  endtask

  task automatic wait_end(input int d, input int bound);
    int n;
    n = 0;
    while (n < bound && !((d == 0) ? (b0.done | b0.error) : (b1.done | b1.error))) begin
      tick();
      n++;
    end
    chk("end_timeout", 32'((d == 0) ? (b0.done | b0.error) : (b1.done | b1.error)), 32'd1);
  endtask

  task automatic chk_rst0(input string tag);
    chk({tag, "_in_ready"}, 32'(b0.in_ready), 32'd0);
    chk({tag, "_addrm"}, 32'(b0.addrm), 32'd0);
    chk({tag, "_wmdata"}, 32'(b0.wmdata), 32'd0);
    chk({tag, "_memwr_en"}, 32'(b0.memwr_en), 32'd0);
    chk({tag, "_owns_bus"}, 32'(b0.owns_bus), 32'd0);
    chk({tag, "_cpu_reset_n"}, 32'(b0.cpu_reset_n), 32'd0);
    chk({tag, "_done"}, 32'(b0.done), 32'd0);
    chk({tag, "_error"}, 32'(b0.error), 32'd0);
    chk({tag, "_words_loaded"}, 32'(b0.words_loaded), 32'd0);
  endtask

  initial begin
    int fb;

    do_reset();
    chk_rst0("rst");

    // Back-to-back load of four words; the first beat's cycle counts as cycle 1.
    start_load(1'b0, 16'd4);
    chk("a_in_ready", 32'(b0.in_ready), 32'd1);
    chk("a_owns_bus", 32'(b0.owns_bus), 32'd1);
    fb = cyc;
    for (int i = 0; i < 4; i++) beat(0, 16'h0000, i, wa[i]);
    valid_s = 1'b0;
    chk("a_in_ready_drop", 32'(b0.in_ready), 32'd0);
    chk("a_words_mid", 32'(b0.words_loaded), 32'd4);
    wait_end(0, 40);
    chk("a_done_latency", 32'(cyc - fb), 32'd10);
    chk("a_done", 32'(b0.done), 32'd1);
    chk("a_error", 32'(b0.error), 32'd0);
    chk("a_cpu_reset_n", 32'(b0.cpu_reset_n), 32'd1);
    chk("a_owns_bus_end", 32'(b0.owns_bus), 32'd0);
    chk("a_words", 32'(b0.words_loaded), 32'd4);
    for (int i = 0; i < 4; i++) chk("a_mem", 32'(mem0[i]), 32'(wa[i]));
    chk("a_mem2_literal", 32'(mem0[2]), 32'h3333);
    start_load(1'b0, 16'd7);
    tick(); tick();
    chk("a_start_ignored_done", 32'(b0.done), 32'd1);
    chk("a_start_ignored_words", 32'(b0.words_loaded), 32'd4);
    $display("load a: dut0 len=4 back-to-back done=%b words=%0d latency=%0d", b0.done, b0.words_loaded, cyc - fb);

    // Same load with three idle cycles between words.
    clr = 1'b1;
    do_reset();
    clr = 1'b0;
    start_load(1'b0, 16'd4);
    for (int i = 0; i < 4; i++) begin
      beat(0, 16'h0000, i, wa[i]);
      valid_s = 1'b0;
      tick(); tick(); tick();
    end
    wait_end(0, 40);
    chk("b_done", 32'(b0.done), 32'd1);
    chk("b_error", 32'(b0.error), 32'd0);
    chk("b_words", 32'(b0.words_loaded), 32'd4);
    for (int i = 0; i < 4; i++) chk("b_mem", 32'(mem0[i]), 32'(wa[i]));
    $display("load b: dut0 len=4 stalled done=%b words=%0d", b0.done, b0.words_loaded);

    // Corrupted word at address 2 must be caught by the readback.
    do_reset();
    corrupt = 1'b1;
    start_load(1'b0, 16'd4);
    for (int i = 0; i < 4; i++) beat(0, 16'h0000, i, wa[i]);
    valid_s = 1'b0;
    wait_end(0, 40);
    chk("c_error", 32'(b0.error), 32'd1);
    chk("c_done", 32'(b0.done), 32'd0);
    chk("c_cpu_reset_n", 32'(b0.cpu_reset_n), 32'd0);
    chk("c_owns_bus", 32'(b0.owns_bus), 32'd0);
    corrupt = 1'b0;
    $display("load c: dut0 len=4 corrupted error=%b done=%b", b0.error, b0.done);

    // Zero-length load completes immediately with no writes.
    do_reset();
    start_load(1'b0, 16'd0);
    chk("d_done", 32'(b0.done), 32'd1);
    chk("d_words", 32'(b0.words_loaded), 32'd0);
    chk("d_owns_bus", 32'(b0.owns_bus), 32'd0);
    tick(); tick();
    $display("load d: dut0 len=0 done=%b", b0.done);

    // Address wrap at the top of memory; extra in_valid after the last word is ignored.
    do_reset();
    start_load(1'b1, 16'd3);
    for (int i = 0; i < 5; i++) begin
      if (i < 3) beat(1, 16'hFFFE, i, wb[i]);
      else begin
        valid_s = 1'b1; data_s = wb[i];
        tick();
      end
    end
    valid_s = 1'b0;
    wait_end(1, 40);
    chk("e_done", 32'(b1.done), 32'd1);
    chk("e_error", 32'(b1.error), 32'd0);
    chk("e_words", 32'(b1.words_loaded), 32'd3);
    chk("e_mem_fffe", 32'(mem1[16'hFFFE]), 32'hAAAA);
    chk("e_mem_ffff", 32'(mem1[16'hFFFF]), 32'hBBBB);
    chk("e_mem_0000", 32'(mem1[16'h0000]), 32'hCCCC);
    $display("load e: dut1 len=3 wrap done=%b words=%0d", b1.done, b1.words_loaded);

    // Reset after two of four words, then a fresh two-word load.
    do_reset();
    start_load(1'b0, 16'd4);
    beat(0, 16'h0000, 0, 16'h0A0A);
    beat(0, 16'h0000, 1, 16'h0B0B);
    valid_s = 1'b0;
    reset = 1'b1;
    tick();
    chk_rst0("f_abort");
    reset = 1'b0;
    start_load(1'b0, 16'd2);
    beat(0, 16'h0000, 0, 16'h5555);
    beat(0, 16'h0000, 1, 16'h6666);
    valid_s = 1'b0;
    wait_end(0, 40);
    chk("f_done", 32'(b0.done), 32'd1);
    chk("f_words", 32'(b0.words_loaded), 32'd2);
    chk("f_mem0", 32'(mem0[0]), 32'h5555);
    chk("f_mem1", 32'(mem0[1]), 32'h6666);
    $display("load f: dut0 reset-abort then len=2 done=%b words=%0d", b0.done, b0.words_loaded);

    tick(); tick();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
